// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants plus the store-buffer entry and drain-state types
// used by the MEM-stage store path.
package rv32i_pkg;

  localparam int DM_ADDR_W = 14;

  // Loads occupy a contiguous code range so the load check can be a range compare.
  localparam logic [5:0] MN_LB  = 6'd10;
  localparam logic [5:0] MN_LH  = 6'd11;
  localparam logic [5:0] MN_LW  = 6'd12;
  localparam logic [5:0] MN_LBU = 6'd13;
  localparam logic [5:0] MN_LHU = 6'd14;
  localparam logic [5:0] MN_SB  = 6'd15;
  localparam logic [5:0] MN_SH  = 6'd16;
  localparam logic [5:0] MN_SW  = 6'd17;

  typedef struct packed {
    logic [DM_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           strb;
  } st_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } drain_state_t;

  function automatic logic is_store_mn(input logic [5:0] mn);
    return (mn == MN_SB) || (mn == MN_SH) || (mn == MN_SW);
  endfunction

  function automatic logic is_load_mn(input logic [5:0] mn);
    return (mn >= MN_LB) && (mn <= MN_LHU);
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic DEPTH-entry FIFO of store entries; a push while full is refused even
// when a pop happens in the same cycle.
module store_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  st_entry_t                din,
  output st_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  st_entry_t          mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store path: aligns store data to byte lanes, buffers stores and drains
// them to data memory over a CS/ready handshake, stalling EX/MEM when needed.
module store_unit
  import rv32i_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [5:0]               i_mnemonic,
  input  logic [31:0]              i_ALUout,
  input  logic [31:0]              i_rs2_data,
  input  logic                     i_DM_ready,
  output logic                     o_DM_CS,
  output logic [ADDR_W-1:0]        o_DM_A,
  output logic [3:0]               o_DM_WEB,
  output logic [31:0]              o_DM_DI,
  output logic                     o_stall,
  output logic                     o_misalign,
  output logic [$clog2(DEPTH):0]   o_pending
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  drain_state_t       state_r;
  logic               misalign_r;
  logic               is_store_s;
  logic               is_load_s;
  logic               mis_s;
  logic [31:0]        al_data_s;
  logic [3:0]         al_strb_s;
  logic               push_s;
  logic               push_ok_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [CNT_W-1:0]   count_s;
  logic [CNT_W-1:0]   count_next_s;
  st_entry_t          entry_s;
  st_entry_t          head_s;
  logic               unused_s;

  assign is_store_s = i_valid & is_store_mn(i_mnemonic);
  assign is_load_s  = i_valid & is_load_mn(i_mnemonic);
  assign unused_s   = ^{i_ALUout[31:DM_ADDR_W+2]};

  // Byte-lane alignment and misalignment detection for the incoming store.
  always_comb begin
    al_data_s = 32'h0000_0000;
    al_strb_s = 4'b0000;
    mis_s     = 1'b0;
    if (is_store_s) begin
      case (i_mnemonic)
        MN_SB: begin
          al_data_s = {4{i_rs2_data[7:0]}};
          al_strb_s = 4'b0001 << i_ALUout[1:0];
        end
        MN_SH: begin
          al_data_s = {2{i_rs2_data[15:0]}};
          al_strb_s = i_ALUout[1] ? 4'b1100 : 4'b0011;
          mis_s     = i_ALUout[0];
        end
        MN_SW: begin
          al_data_s = i_rs2_data;
          al_strb_s = 4'b1111;
          mis_s     = (i_ALUout[1:0] != 2'b00);
        end
        default: begin
          al_data_s = 32'h0000_0000;
          al_strb_s = 4'b0000;
          mis_s     = 1'b0;
        end
      endcase
    end else begin
      mis_s = 1'b0;
    end
  end

  assign entry_s      = '{addr: i_ALUout[DM_ADDR_W+1:2], data: al_data_s, strb: al_strb_s};
  assign push_s       = is_store_s & ~mis_s;
  assign push_ok_s    = push_s & ~full_s;
  assign pop_s        = (state_r == ISSUE) & i_DM_ready & ~empty_s;
  assign count_next_s = count_s + CNT_W'(push_ok_s) - CNT_W'(pop_s);

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (entry_s),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Drain FSM; looking at the next count lets a push made in IDLE be presented next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= is_store_s & mis_s;
      case (state_r)
        IDLE: begin
          state_r <= (count_next_s != {CNT_W{1'b0}}) ? ISSUE : IDLE;
        end
        ISSUE: begin
          if (i_DM_ready) begin
            state_r <= (count_next_s != {CNT_W{1'b0}}) ? ISSUE : IDLE;
          end else begin
            state_r <= ISSUE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Memory-side outputs are decoded from flops only, so they hold steady until ready.
  assign o_DM_CS    = (state_r == ISSUE);
  assign o_DM_A     = (state_r == ISSUE) ? ADDR_W'(head_s.addr) : {ADDR_W{1'b0}};
  assign o_DM_DI    = (state_r == ISSUE) ? head_s.data : 32'h0000_0000;
  assign o_DM_WEB   = (state_r == ISSUE) ? ~head_s.strb : 4'hF;
  assign o_misalign = misalign_r;
  assign o_pending  = count_s;
  assign o_stall    = (push_s & full_s) | (is_load_s & (count_s != {CNT_W{1'b0}}));

endmodule

// File: tb/tb_store_unit.sv
// Directed, table-driven bench for store_unit: one record per cycle, plus
// hand-written reset-during-transfer and reset-state checks.
module tb_store_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [5:0]  i_mnemonic;
  logic [31:0] i_ALUout;
  logic [31:0] i_rs2_data;
  logic        i_DM_ready;
  logic        o_DM_CS;
  logic [13:0] o_DM_A;
  logic [3:0]  o_DM_WEB;
  logic [31:0] o_DM_DI;
  logic        o_stall;
  logic        o_misalign;
  logic [1:0]  o_pending;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        v;
    logic [5:0]  mn;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        rdy;
    logic        cs;
    logic [13:0] a;
    logic [3:0]  web;
    logic [31:0] di;
    logic        stall;
    logic        mis;
    logic [1:0]  pend;
  } vec_t;

  vec_t vecs[$];

  store_unit #(.DEPTH(2), .ADDR_W(14)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_mnemonic (i_mnemonic),
    .i_ALUout   (i_ALUout),
    .i_rs2_data (i_rs2_data),
    .i_DM_ready (i_DM_ready),
    .o_DM_CS    (o_DM_CS),
    .o_DM_A     (o_DM_A),
    .o_DM_WEB   (o_DM_WEB),
    .o_DM_DI    (o_DM_DI),
    .o_stall    (o_stall),
    .o_misalign (o_misalign),
    .o_pending  (o_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [1:0] pend);
    chk({tag, " cs"},   32'(o_DM_CS),   32'h0);
    chk({tag, " web"},  32'(o_DM_WEB),  32'hF);
    chk({tag, " a"},    32'(o_DM_A),    32'h0);
    chk({tag, " di"},   o_DM_DI,        32'h0);
    chk({tag, " pend"}, 32'(o_pending), 32'(pend));
  endtask

  // Outputs expected in the cycle in which the given inputs are applied.
  task automatic add(input logic v, input logic [5:0] mn, input logic [31:0] alu,
                     input logic [31:0] rs2, input logic rdy, input logic cs,
                     input logic [13:0] a, input logic [3:0] web, input logic [31:0] di,
                     input logic stall, input logic mis, input logic [1:0] pend);
    vec_t r;
    r.v = v; r.mn = mn; r.alu = alu; r.rs2 = rs2; r.rdy = rdy;
    r.cs = cs; r.a = a; r.web = web; r.di = di; r.stall = stall; r.mis = mis; r.pend = pend;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [5:0] mn, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic rdy);
    i_valid = v; i_mnemonic = mn; i_ALUout = alu; i_rs2_data = rs2; i_DM_ready = rdy;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 6'd0, 32'h0, 32'h0, 1'b0);
    #12;
    chk_idle("reset", 2'd0);
    chk("reset mis", 32'(o_misalign), 32'h0);

    // SB lane replication and strobe shift
    add(1, MN_SB, 32'h6,   32'h1234_56AB, 1, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    add(0, 6'd0,  32'h0,   32'h0,         1, 1, 14'h1,  4'b1011, 32'hABAB_ABAB, 0, 0, 1);
    add(0, 6'd0,  32'h0,   32'h0,         1, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    // SH upper half, then misaligned SW
    add(1, MN_SH, 32'h12,  32'h0000_BEEF, 1, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    add(1, MN_SW, 32'h13,  32'hDEAD_BEEF, 1, 1, 14'h4,  4'b0011, 32'hBEEF_BEEF, 0, 0, 1);
    add(0, 6'd0,  32'h0,   32'h0,         1, 0, 14'h0,  4'hF,    32'h0,         0, 1, 0);
    add(0, 6'd0,  32'h0,   32'h0,         1, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    // Three SWs into a two-entry buffer; full push refused despite a same-cycle pop
    add(1, MN_SW, 32'h100, 32'h1111_1111, 0, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    add(1, MN_SW, 32'h104, 32'h2222_2222, 0, 1, 14'h40, 4'h0,    32'h1111_1111, 0, 0, 1);
    add(1, MN_SW, 32'h108, 32'h3333_3333, 1, 1, 14'h40, 4'h0,    32'h1111_1111, 1, 0, 2);
    add(1, MN_SW, 32'h108, 32'h3333_3333, 0, 1, 14'h41, 4'h0,    32'h2222_2222, 0, 0, 1);
    add(0, 6'd0,  32'h0,   32'h0,         1, 1, 14'h41, 4'h0,    32'h2222_2222, 0, 0, 2);
    add(0, 6'd0,  32'h0,   32'h0,         1, 1, 14'h42, 4'h0,    32'h3333_3333, 0, 0, 1);
    add(0, 6'd0,  32'h0,   32'h0,         0, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    // Load waits for the buffer to drain
    add(1, MN_SW, 32'h200, 32'h4444_4444, 0, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    add(1, MN_LW, 32'h300, 32'h0,         0, 1, 14'h80, 4'h0,    32'h4444_4444, 1, 0, 1);
    add(1, MN_LW, 32'h300, 32'h0,         0, 1, 14'h80, 4'h0,    32'h4444_4444, 1, 0, 1);
    add(1, MN_LW, 32'h300, 32'h0,         1, 1, 14'h80, 4'h0,    32'h4444_4444, 1, 0, 1);
    add(1, MN_LW, 32'h300, 32'h0,         0, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    // Streaming SWs with ready held high; pointers wrap twice
    add(1, MN_SW, 32'h0,   32'h0000_00A0, 1, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    add(1, MN_SW, 32'h4,   32'h0000_00A1, 1, 1, 14'h0,  4'h0,    32'h0000_00A0, 0, 0, 1);
    add(1, MN_SW, 32'h8,   32'h0000_00A2, 1, 1, 14'h1,  4'h0,    32'h0000_00A1, 0, 0, 1);
    add(1, MN_SW, 32'hC,   32'h0000_00A3, 1, 1, 14'h2,  4'h0,    32'h0000_00A2, 0, 0, 1);
    add(0, 6'd0,  32'h0,   32'h0,         1, 1, 14'h3,  4'h0,    32'h0000_00A3, 0, 0, 1);
    add(0, 6'd0,  32'h0,   32'h0,         1, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    // SB top lane, then SH at odd address
    add(1, MN_SB, 32'h3,   32'h0000_00CD, 1, 0, 14'h0,  4'hF,    32'h0,         0, 0, 0);
    add(1, MN_SH, 32'h1,   32'h0000_1234, 1, 1, 14'h0,  4'b0111, 32'hCDCD_CDCD, 0, 0, 1);
    add(0, 6'd0,  32'h0,   32'h0,         1, 0, 14'h0,  4'hF,    32'h0,         0, 1, 0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].mn, vecs[i].alu, vecs[i].rs2, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d cs", i),    32'(o_DM_CS),    32'(vecs[i].cs));
      chk($sformatf("v%0d a", i),     32'(o_DM_A),     32'(vecs[i].a));
      chk($sformatf("v%0d web", i),   32'(o_DM_WEB),   32'(vecs[i].web));
      chk($sformatf("v%0d di", i),    o_DM_DI,         vecs[i].di);
      chk($sformatf("v%0d stall", i), 32'(o_stall),    32'(vecs[i].stall));
      chk($sformatf("v%0d mis", i),   32'(o_misalign), 32'(vecs[i].mis));
      chk($sformatf("v%0d pend", i),  32'(o_pending),  32'(vecs[i].pend));
    end

    // Reset in the middle of an ISSUE with two entries buffered
    @(negedge clk);
    drive(1'b1, MN_SW, 32'h40, 32'h5555_5555, 1'b0);
    @(negedge clk);
    drive(1'b1, MN_SW, 32'h44, 32'h6666_6666, 1'b0);
    @(negedge clk);
    drive(1'b0, 6'd0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("pre-rst cs",   32'(o_DM_CS),   32'h1);
    chk("pre-rst pend", 32'(o_pending), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("mid-rst", 2'd0);
    @(negedge clk);
    rst = 1'b1;
    i_DM_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst%0d cs", k),   32'(o_DM_CS),   32'h0);
      chk($sformatf("post-rst%0d pend", k), 32'(o_pending), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
